// File: rtl/mmio_write_bridge_pkg.sv
// mmio_pkg: constants and types shared by the MMIO write bridge slice.
//   MMIO_REGION   - value of core_addr[31:28] that selects the MMIO window
//   STATUS_OFFSET - word offset of the status register inside the window
//   wbuf_entry_t  - posted-write FIFO entry {offset, data} at the default width
package mmio_pkg;

    localparam logic [3:0] MMIO_REGION   = 4'hF;
    localparam logic [7:0] STATUS_OFFSET = 8'h00;
    localparam int         MMIO_N        = 32;

    typedef struct packed {
        logic [7:0]        offset;
        logic [MMIO_N-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/mmio_write_bridge_if.sv
// mmio_write_bridge_if: core, RAM and peripheral-bus signals of the bridge.
//   slave  - bridge view (drives RAM/peripheral/read data)
//   master - environment view (drives core strobe/address/data, RAM data, ready)
interface mmio_write_bridge_if #(
    parameter int N = 32
);
    logic         mem_we;
    logic [N-1:0] core_addr;
    logic [N-1:0] core_wdata;
    logic [N-1:0] core_rdata;
    logic [N-1:0] ram_addr;
    logic [N-1:0] ram_wdata;
    logic         ram_we;
    logic [N-1:0] ram_rdata;
    logic         per_valid;
    logic         per_ready;
    logic [7:0]   per_addr;
    logic [N-1:0] per_data;
    logic         wbuf_ovf;

    modport slave (
        input  mem_we, core_addr, core_wdata, ram_rdata, per_ready,
        output core_rdata, ram_addr, ram_wdata, ram_we,
               per_valid, per_addr, per_data, wbuf_ovf
    );

    modport master (
        output mem_we, core_addr, core_wdata, ram_rdata, per_ready,
        input  core_rdata, ram_addr, ram_wdata, ram_we,
               per_valid, per_addr, per_data, wbuf_ovf
    );
endinterface

// File: rtl/mmio_write_bridge_wbuf_fifo.sv
// wbuf_fifo: posted-write FIFO (storage, wrapping pointers, occupancy count).
//   clk, rst         - clock, async active-low reset
//   push, push_data  - write an entry (caller guarantees not full unless pop)
//   pop              - remove the head (caller guarantees not empty)
//   head             - oldest entry
//   full, empty      - occupancy flags
//   count            - entries held, 0..DEPTH
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    assign head  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/mmio_write_bridge.sv
// mmio_write_bridge: splits core stores between RAM and a posted MMIO write
// buffer draining onto a valid/ready peripheral bus; muxes read data.
//   clk  - single clock
//   rst  - async active-low reset
//   bus  - mmio_write_bridge_if.slave (core, RAM and peripheral signals)
// Build option: define MMIO_STATUS_EN to return {wbuf_ovf, count} on MMIO
// reads of the status offset; otherwise all MMIO reads return zero.
module mmio_write_bridge
    import mmio_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    mmio_write_bridge_if.slave bus
);
    localparam int ENTRY_W = 8 + N;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               is_mmio;
    logic               push_req;
    logic               push_en;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic [ENTRY_W-1:0] head;
    logic               ovf_q;
    logic               sel_q;
    logic [N-1:0]       mmio_word;

    assign is_mmio  = (bus.core_addr[31:28] == MMIO_REGION);
    assign push_req = bus.mem_we & is_mmio;
    assign pop      = bus.per_valid & bus.per_ready;
    // A full buffer still accepts a write when the head leaves the same cycle.
    assign push_en  = push_req & (~full | pop);

    assign bus.ram_addr  = bus.core_addr;
    assign bus.ram_wdata = bus.core_wdata;
    assign bus.ram_we    = bus.mem_we & ~is_mmio;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en),
        .push_data ({bus.core_addr[9:2], bus.core_wdata}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign bus.per_valid = ~empty;
    assign bus.per_addr  = head[ENTRY_W-1 -: 8];
    assign bus.per_data  = head[N-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (push_req && full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.wbuf_ovf = ovf_q;

    // Read source is registered so MMIO reads share the RAM's one-cycle latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sel_q <= 1'b0;
        else      sel_q <= is_mmio;
    end

`ifdef MMIO_STATUS_EN
    logic       stat_q;
    logic [4:0] count5;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stat_q <= 1'b0;
        else      stat_q <= (bus.core_addr[9:2] == STATUS_OFFSET);
    end

    assign count5    = 5'(count);
    assign mmio_word = stat_q ? N'({ovf_q, 26'b0, count5}) : '0;
`else
    assign mmio_word = '0;
`endif

    assign bus.core_rdata = sel_q ? mmio_word : bus.ram_rdata;
endmodule
